warp_fetch_unit: RTL
====================

WARP_FETCH_UNIT -- requirements
Module: warp_fetch_unit

Interface
REQ-001 SHALL have parameter NUM_WARPS, default 8, meaning the number of warp PC contexts; WID_W = $clog2(NUM_WARPS).
REQ-002 SHALL have parameter ADDR_W, default 32, meaning the PC width in bytes-address form.
REQ-003 SHALL have parameter DATA_W, default 64, meaning the instruction width; the PC step is DATA_W/8 bytes.
REQ-004 SHALL have parameter IBUF_DEPTH, default 2, meaning instruction-buffer entries per warp.
REQ-005 clk  in  1  single clock; all state SHALL be on the rising edge.
REQ-006 rst  in  1  reset, asynchronous, active-high.
REQ-007 launch_valid/launch_wid/launch_pc  in  1/WID_W/ADDR_W  activate a warp at a start PC.
REQ-008 exit_valid/exit_wid  in  1/WID_W  deactivate a warp.
REQ-009 redir_valid/redir_wid/redir_pc  in  1/WID_W/ADDR_W  branch redirect.
REQ-010 ic_req/ic_pc/ic_wid  out  1/ADDR_W/WID_W  fetch request to the instruction cache.
REQ-011 ic_valid/ic_instr  in  1/DATA_W  cache response.
REQ-012 ibuf_nonempty  out  NUM_WARPS  per-warp "head instruction available".
REQ-013 iss_wid  in  WID_W  warp selected by the scheduler.
REQ-014 iss_instr/iss_pc  out  DATA_W/ADDR_W  head of the buffer for iss_wid, combinational.
REQ-015 iss_pop  in  1  dequeue the head of iss_wid.

Function
REQ-016 Per warp SHALL hold: active, pc, and an IBUF_DEPTH FIFO of {instr, pc}.
REQ-017 FSM states: IDLE, WAIT. IDLE->WAIT when an eligible warp exists; WAIT->IDLE on ic_valid.
REQ-018 A warp is eligible when active and (FIFO count + in-flight for that warp) < IBUF_DEPTH.
REQ-019 In IDLE, the next warp SHALL be selected round-robin, starting from (last granted + 1) mod NUM_WARPS.
REQ-020 ic_req SHALL be registered: asserted the cycle after selection and held stable with ic_pc/ic_wid until ic_valid is seen.
REQ-021 At most one fetch SHALL be outstanding; ic_valid while ic_req=0 SHALL be ignored.
REQ-022 On ic_valid (not squashed), {ic_instr, ic_pc} SHALL be pushed to ic_wid's FIFO and that warp's pc advanced by DATA_W/8, wrapping modulo 2^ADDR_W.
REQ-023 Minimum fetch-to-fetch spacing: ic_valid in cycle N allows the next ic_req in cycle N+1.
REQ-024 Redirect SHALL, in the same edge, set pc=redir_pc, flush that warp's FIFO, and mark any in-flight fetch for that warp squashed; a squashed response SHALL be dropped without a PC update.
REQ-025 Exit SHALL clear active, flush the FIFO, and squash in-flight as for redirect.
REQ-026 Launch SHALL be accepted only for an inactive warp; a launch to an active warp SHALL be ignored.
REQ-027 Same-warp precedence in one cycle: exit > redirect > response push > iss_pop; a pop coinciding with a flush SHALL be lost.
REQ-028 Push and pop on the same FIFO in one cycle SHALL both occur; count is unchanged.
REQ-029 iss_pop on an empty FIFO SHALL be ignored; iss_instr/iss_pc for an empty FIFO SHALL be 0.
REQ-030 The FIFO SHALL never overflow, guaranteed by REQ-018.

Reset
REQ-031 While rst is high: all warps inactive, all pcs 0, FIFOs empty, FSM IDLE, RR pointer NUM_WARPS-1, and squash cleared.
REQ-032 While rst is high, ic_req, ic_pc, ic_wid and ibuf_nonempty SHALL be 0.
REQ-033 A response arriving after reset release for a pre-reset request SHALL be ignored per REQ-021.

Structure
REQ-034 A shared package SHALL hold the state enum (IDLE, WAIT) and the ibuf entry struct {instr, pc}.
REQ-035 The per-warp FIFO SHALL be a sub-module warp_ibuf (parameters DEPTH, W; ports push, pop, flush, count, head), instantiated NUM_WARPS times.

Verification
REQ-036 Launch w0 at pc 0x100; the cache responds 2 cycles after each request -> ic_pc sequence 0x100, 0x108; FIFO full after two fetches; no third ic_req until iss_pop.
REQ-037 Launch w0 and w3 together with 1-cycle cache latency -> grants alternate 0, 3, 0, 3 until both FIFOs are full.
REQ-038 Redirect w0 to 0x400 while its fetch of 0x108 is in flight -> that response is dropped, the FIFO is empty, and the next ic_pc is 0x400.
REQ-039 Full FIFO with iss_pop and ic_valid push in the same cycle -> count stays 2 and head advances.
REQ-040 w0 pc 0xFFFFFFF8 fetched -> pc wraps to 0x0; then exit w0 -> ibuf_nonempty[0]=0 and no further w0 requests.
REQ-041 rst asserted while in WAIT -> ic_req=0 immediately; a stray ic_valid after release changes nothing.

Source files
------------

// File: rtl/warp_fetch_unit_pkg.sv
// rtl/warp_fetch_unit_pkg.sv - shared types for the warp fetch unit
package warp_fetch_unit_pkg;

    // Fetch sequencer: IDLE looks for an eligible warp, WAIT holds one request open.
    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } fetch_state_e;

    // Instruction-buffer entry at the default geometry (64-bit instruction, 32-bit PC).
    // The top packs the same {instr, pc} layout at whatever widths it is built with.
    localparam int ENTRY_DATA_W = 64;
    localparam int ENTRY_ADDR_W = 32;

    typedef struct packed {
        logic [ENTRY_DATA_W-1:0] instr;
        logic [ENTRY_ADDR_W-1:0] pc;
    } ibuf_entry_t;

endpackage

// File: rtl/warp_fetch_unit_ibuf.sv
// rtl/warp_fetch_unit_ibuf.sv - per-warp instruction FIFO with flush
module warp_ibuf
    import warp_fetch_unit_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int W     = 96,
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  logic          flush,
    input  logic [W-1:0]  din,
    output logic [CW-1:0] count,
    output logic [W-1:0]  head
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic          do_pop;
    logic          do_push;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // A pop of an empty buffer is dropped; a push into a full buffer only lands if a pop frees a slot.
    assign do_pop  = pop && (count != '0);
    assign do_push = push && ((count != CW'(DEPTH)) || do_pop);
    assign head    = (count != '0) ? mem[rd_ptr] : '0;

    // Pointer and occupancy tracking; flush wins over any push/pop in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_pop) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            if (do_push) begin
                wr_ptr <= next_ptr(wr_ptr);
            end
            if (do_push && !do_pop) begin
                count <= count + CW'(1);
            end else if (do_pop && !do_push) begin
                count <= count - CW'(1);
            end
        end
    end

    // Entry storage; contents are only meaningful below the occupancy count.
    always_ff @(posedge clk) begin
        if (do_push && !flush) begin
            mem[wr_ptr] <= din;
        end
    end

endmodule

// File: rtl/warp_fetch_unit.sv
// rtl/warp_fetch_unit.sv - round-robin multi-warp instruction fetch front end
module warp_fetch_unit
    import warp_fetch_unit_pkg::*;
#(
    parameter int NUM_WARPS  = 8,
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 64,
    parameter int IBUF_DEPTH = 2,
    localparam int WID_W     = $clog2(NUM_WARPS)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 launch_valid,
    input  logic [WID_W-1:0]     launch_wid,
    input  logic [ADDR_W-1:0]    launch_pc,
    input  logic                 exit_valid,
    input  logic [WID_W-1:0]     exit_wid,
    input  logic                 redir_valid,
    input  logic [WID_W-1:0]     redir_wid,
    input  logic [ADDR_W-1:0]    redir_pc,
    output logic                 ic_req,
    output logic [ADDR_W-1:0]    ic_pc,
    output logic [WID_W-1:0]     ic_wid,
    input  logic                 ic_valid,
    input  logic [DATA_W-1:0]    ic_instr,
    output logic [NUM_WARPS-1:0] ibuf_nonempty,
    input  logic [WID_W-1:0]     iss_wid,
    output logic [DATA_W-1:0]    iss_instr,
    output logic [ADDR_W-1:0]    iss_pc,
    input  logic                 iss_pop
);

    localparam int CW      = $clog2(IBUF_DEPTH + 1);
    localparam int ENTRY_W = DATA_W + ADDR_W;
    localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(DATA_W / 8);

    fetch_state_e           state;
    logic [WID_W-1:0]       rr_ptr;
    logic                   squash;

    logic                   active  [NUM_WARPS];
    logic [ADDR_W-1:0]      pc      [NUM_WARPS];
    logic [ADDR_W-1:0]      pc_next [NUM_WARPS];
    logic [CW-1:0]          count   [NUM_WARPS];
    logic [ENTRY_W-1:0]     head    [NUM_WARPS];
    logic [ENTRY_W-1:0]     iss_head;

    logic [NUM_WARPS-1:0]   exit_hit;
    logic [NUM_WARPS-1:0]   redir_hit;
    logic [NUM_WARPS-1:0]   flush;
    logic [NUM_WARPS-1:0]   push;
    logic [NUM_WARPS-1:0]   pop;
    logic [NUM_WARPS-1:0]   elig;

    logic                   push_fire;
    logic                   sel_any;
    logic [WID_W-1:0]       sel_wid;
    logic [WID_W-1:0]       cand;

    // A response is kept only if its warp was not flushed while the fetch was out or in this very cycle.
    assign push_fire = ic_req && ic_valid && !squash && !flush[ic_wid];

    for (genvar w = 0; w < NUM_WARPS; w++) begin : g_warp
        logic inflight;

        assign exit_hit[w]  = exit_valid && (exit_wid == WID_W'(w));
        assign redir_hit[w] = redir_valid && (redir_wid == WID_W'(w));
        assign flush[w]     = exit_hit[w] || redir_hit[w];
        assign push[w]      = push_fire && (ic_wid == WID_W'(w));
        assign pop[w]       = iss_pop && (iss_wid == WID_W'(w)) && !flush[w];
        assign inflight     = ic_req && (ic_wid == WID_W'(w));
        // A warp being flushed this cycle is not fetched from its stale PC.
        assign elig[w]      = active[w] && !flush[w] &&
                              (({1'b0, count[w]} + (CW + 1)'(inflight)) < (CW + 1)'(IBUF_DEPTH));
        assign ibuf_nonempty[w] = (count[w] != '0);

        // Next PC for this warp: exit freezes it, then redirect, launch, and sequential advance.
        always_comb begin
            pc_next[w] = pc[w];
            if (exit_hit[w]) begin
                pc_next[w] = pc[w];
            end else if (redir_hit[w]) begin
                pc_next[w] = redir_pc;
            end else if (launch_valid && (launch_wid == WID_W'(w)) && !active[w]) begin
                pc_next[w] = launch_pc;
            end else if (push[w]) begin
                pc_next[w] = pc[w] + PC_STEP;
            end
        end

        // Warp context: activation on launch of an idle warp, deactivation on exit.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                active[w] <= 1'b0;
                pc[w]     <= '0;
            end else begin
                if (exit_hit[w]) begin
                    active[w] <= 1'b0;
                end else if (launch_valid && (launch_wid == WID_W'(w))) begin
                    active[w] <= 1'b1;
                end
                pc[w] <= pc_next[w];
            end
        end

        warp_ibuf #(
            .DEPTH (IBUF_DEPTH),
            .W     (ENTRY_W)
        ) u_ibuf (
            .clk   (clk),
            .rst   (rst),
            .push  (push[w]),
            .pop   (pop[w]),
            .flush (flush[w]),
            .din   ({ic_instr, ic_pc}),
            .count (count[w]),
            .head  (head[w])
        );
    end

    // Round-robin pick of the first eligible warp after the last grant.
    always_comb begin
        sel_any = 1'b0;
        sel_wid = rr_ptr;
        cand    = rr_ptr;
        for (int i = 1; i <= NUM_WARPS; i++) begin
            cand = WID_W'((int'(rr_ptr) + i) % NUM_WARPS);
            if (!sel_any && elig[cand]) begin
                sel_any = 1'b1;
                sel_wid = cand;
            end
        end
    end

    // Fetch sequencer; a grant in the response cycle keeps back-to-back fetches one cycle apart.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            rr_ptr <= WID_W'(NUM_WARPS - 1);
            squash <= 1'b0;
            ic_req <= 1'b0;
            ic_pc  <= '0;
            ic_wid <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (sel_any) begin
                        state  <= WAIT;
                        ic_req <= 1'b1;
                        ic_pc  <= pc_next[sel_wid];
                        ic_wid <= sel_wid;
                        rr_ptr <= sel_wid;
                        squash <= 1'b0;
                    end
                end
                WAIT: begin
                    if (ic_valid) begin
                        squash <= 1'b0;
                        if (sel_any) begin
                            ic_pc  <= pc_next[sel_wid];
                            ic_wid <= sel_wid;
                            rr_ptr <= sel_wid;
                        end else begin
                            state  <= IDLE;
                            ic_req <= 1'b0;
                        end
                    end else if (flush[ic_wid]) begin
                        squash <= 1'b1;
                    end
                end
                default: begin
                    state  <= IDLE;
                    ic_req <= 1'b0;
                end
            endcase
        end
    end

    assign iss_head  = head[iss_wid];
    assign iss_instr = iss_head[ENTRY_W-1:ADDR_W];
    assign iss_pc    = iss_head[ADDR_W-1:0];

endmodule
